// File: rtl/adt7420_bcd_converter.sv
// ADT7420 13-bit temperature word to sign + 3 integer BCD digits + 2 fraction BCD digits.
// Define ADT7420_BCD_ROUND_EN to round hundredths half-up; the default build truncates.
module adt7420_bcd_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_sign,
  output logic [3:0]  out_hund,
  output logic [3:0]  out_tens,
  output logic [3:0]  out_ones,
  output logic [3:0]  out_tenth,
  output logic [3:0]  out_hundth,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CONV = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q;
  logic [12:0] raw_q;
  logic        sign_q;
  logic [13:0] int_bin_q;
  logic [13:0] frac_bin_q;
  logic [15:0] int_bcd_q;
  logic [15:0] frac_bcd_q;
  logic [3:0]  cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_sign_q;
  logic [3:0]  out_hund_q, out_tens_q, out_ones_q, out_tenth_q, out_hundth_q;

  logic [13:0] mag_d;
  logic [13:0] frac_prod_d;
  logic [15:0] int_bcd_d;
  logic [15:0] frac_bcd_d;
  logic [3:0]  tenth_d;
  logic [3:0]  hundth_d;
  logic        unused_bits;

  assign unused_bits = ^in_data[2:0];

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic b);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return {adj[14:0], b};
  endfunction

  // Magnitude, fraction product, next BCD step and final fraction digits.
  always_comb begin
    if (raw_q[12]) begin
      mag_d = 14'd0 - {raw_q[12], raw_q};
    end else begin
      mag_d = {1'b0, raw_q};
    end
    frac_prod_d = {10'd0, mag_d[3:0]} * 14'd625;
    int_bcd_d   = dd_step(int_bcd_q, int_bin_q[13]);
    frac_bcd_d  = dd_step(frac_bcd_q, frac_bin_q[13]);
`ifdef ADT7420_BCD_ROUND_EN
    // Tens digit of the fraction is the round digit; it never carries past tenths.
    if (frac_bcd_d[7:4] >= 4'd5) begin
      if (frac_bcd_d[11:8] == 4'd9) begin
        hundth_d = 4'd0;
        tenth_d  = frac_bcd_d[15:12] + 4'd1;
      end else begin
        hundth_d = frac_bcd_d[11:8] + 4'd1;
        tenth_d  = frac_bcd_d[15:12];
      end
    end else begin
      hundth_d = frac_bcd_d[11:8];
      tenth_d  = frac_bcd_d[15:12];
    end
`else
    hundth_d = frac_bcd_d[11:8];
    tenth_d  = frac_bcd_d[15:12];
`endif
  end

  // Control FSM with conversion datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      raw_q        <= 13'd0;
      sign_q       <= 1'b0;
      int_bin_q    <= 14'd0;
      frac_bin_q   <= 14'd0;
      int_bcd_q    <= 16'd0;
      frac_bcd_q   <= 16'd0;
      cnt_q        <= 4'd0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_hund_q   <= 4'h0;
      out_tens_q   <= 4'h0;
      out_ones_q   <= 4'h0;
      out_tenth_q  <= 4'h0;
      out_hundth_q <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            raw_q      <= in_data[15:3];
            in_ready_q <= 1'b0;
            state_q    <= LOAD;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          sign_q     <= raw_q[12];
          int_bin_q  <= {4'd0, mag_d[13:4]};
          frac_bin_q <= frac_prod_d;
          int_bcd_q  <= 16'd0;
          frac_bcd_q <= 16'd0;
          cnt_q      <= 4'd0;
          state_q    <= CONV;
        end
        CONV: begin
          int_bcd_q  <= int_bcd_d;
          frac_bcd_q <= frac_bcd_d;
          int_bin_q  <= {int_bin_q[12:0], 1'b0};
          frac_bin_q <= {frac_bin_q[12:0], 1'b0};
          if (cnt_q == 4'd13) begin
            cnt_q        <= 4'd0;
            out_sign_q   <= sign_q;
            out_hund_q   <= int_bcd_d[11:8];
            out_tens_q   <= int_bcd_d[7:4];
            out_ones_q   <= int_bcd_d[3:0];
            out_tenth_q  <= tenth_d;
            out_hundth_q <= hundth_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sign   = out_sign_q;
  assign out_hund   = out_hund_q;
  assign out_tens   = out_tens_q;
  assign out_ones   = out_ones_q;
  assign out_tenth  = out_tenth_q;
  assign out_hundth = out_hundth_q;

endmodule

// File: tb/tb_adt7420_bcd_converter.sv
// Directed, table-driven bench for adt7420_bcd_converter (expectations follow ADT7420_BCD_ROUND_EN).
module tb_adt7420_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_sign;
  logic [3:0]  out_hund, out_tens, out_ones, out_tenth, out_hundth;
  logic        out_valid;
  logic        out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef ADT7420_BCD_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[13];

  adt7420_bcd_converter dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sign(out_sign), .out_hund(out_hund), .out_tens(out_tens), .out_ones(out_ones),
    .out_tenth(out_tenth), .out_hundth(out_hundth), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] pk(input logic s, input logic [3:0] h, input logic [3:0] t,
                                     input logic [3:0] o, input logic [3:0] te, input logic [3:0] hu);
    return {s, h, t, o, te, hu};
  endfunction

  function automatic logic [20:0] dut_res();
    return {out_sign, out_hund, out_tens, out_ones, out_tenth, out_hundth};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for in_ready, transfer d, count edges until out_valid (lat = -1 on timeout).
  task automatic send_and_wait(input logic [15:0] d, output int lat);
    int k;
    k = 0;
    lat = -1;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_done();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    logic [20:0] held;

    vecs[0]  = '{"p25_0625",  16'h0C88, pk(1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 4'd6)};
    vecs[1]  = '{"m0_0625",   16'hFFF8, pk(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6)};
    vecs[2]  = '{"m64_0",     16'hE000, pk(1'b1, 4'd0, 4'd6, 4'd4, 4'd0, 4'd0)};
    vecs[3]  = '{"m256_0",    16'h8000, pk(1'b1, 4'd2, 4'd5, 4'd6, 4'd0, 4'd0)};
    vecs[4]  = '{"p24_9375",  16'h0C78, pk(1'b0, 4'd0, 4'd2, 4'd4, 4'd9, RND ? 4'd4 : 4'd3)};
    vecs[5]  = '{"p150_0",    16'h4B00, pk(1'b0, 4'd1, 4'd5, 4'd0, 4'd0, 4'd0)};
    vecs[6]  = '{"zero",      16'h0000, pk(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0)};
    vecs[7]  = '{"zero_lsbs", 16'h0007, pk(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0)};
    vecs[8]  = '{"p255_9375", 16'h7FF8, pk(1'b0, 4'd2, 4'd5, 4'd5, 4'd9, RND ? 4'd4 : 4'd3)};
    vecs[9]  = '{"p0_0625",   16'h0008, pk(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6)};
    vecs[10] = '{"m2_0",      16'hFF00, pk(1'b1, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0)};
    vecs[11] = '{"p24_625",   16'h0C50, pk(1'b0, 4'd0, 4'd2, 4'd4, 4'd6, RND ? 4'd3 : 4'd2)};
    vecs[12] = '{"m0_1875",   16'hFFE8, pk(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, RND ? 4'd9 : 4'd8)};

    rst = 1'b1;
    in_data = 16'h0000;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_digits", {11'd0, dut_res()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      send_and_wait(vecs[i].data, lat);
      check({vecs[i].name, "_latency"}, lat, 32'd15);
      check(vecs[i].name, {11'd0, dut_res()}, {11'd0, vecs[i].exp});
      release_done();
    end

    // Back-pressure: result must hold for 20 cycles while new input is offered.
    send_and_wait(16'h0C78, lat);
    check("hold_latency", lat, 32'd15);
    held = dut_res();
    check("hold_first", {11'd0, held}, {11'd0, vecs[4].exp});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_data  = 16'h4B00;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_res() !== held) begin
        check($sformatf("hold_cycle%0d", c), {in_ready, out_valid, 9'd0, dut_res()},
              {1'b0, 1'b1, 9'd0, held});
      end
    end
    n_cmp++;
    @(negedge clk);
    in_valid = 1'b0;
    release_done();
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("held_input_ignored", seen, 32'd0);

    // Reset pulse during CONV iteration 7 aborts the sample.
    @(negedge clk);
    in_data  = 16'h4B00;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midconv_rst_digits", {11'd0, dut_res()}, 32'd0);
    check("midconv_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midconv_in_ready_after", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("aborted_never_valid", seen, 32'd0);
    check("aborted_digits_zero", {11'd0, dut_res()}, 32'd0);
    send_and_wait(16'h0C88, lat);
    check("post_abort_latency", lat, 32'd15);
    check("post_abort_result", {11'd0, dut_res()}, {11'd0, vecs[0].exp});
    release_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
